// File: rtl/mmu_ctrl_pkg.sv
// Shared state encoding and array-derived timing constants for the systolic MMU sequencer.
package mmu_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        WLOAD = 3'd1,
        FEED  = 3'd2,
        DRAIN = 3'd3,
        DONE  = 3'd4
    } mmu_state_e;

    localparam int ARRAY_DIM_DEF  = 4;
    localparam int ADDR_WIDTH_DEF = 8;

    // Zero-filled cycles needed to flush the last real row through an n x n array.
    function automatic int drain_cyc(input int n);
        return (32'sd2 * n) - 32'sd1;
    endfunction

    // Cycles from the first active cycle to the first valid result row.
    function automatic int out_lat(input int n);
        return (32'sd2 * n) - 32'sd1;
    endfunction

    localparam int DRAIN_CYC = drain_cyc(ARRAY_DIM_DEF);
    localparam int OUT_LAT   = out_lat(ARRAY_DIM_DEF);

endpackage

// File: rtl/mmu_ctrl_cnt.sv
// Loadable up-counter with terminal-count compare; exposes the next count so callers
// can register values derived from it in the same cycle the count register updates.
module mmu_ctrl_cnt
    import mmu_ctrl_pkg::*;
#(
    parameter int WIDTH = ADDR_WIDTH_DEF + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             inc,
    input  logic [WIDTH-1:0] last,
    output logic [WIDTH-1:0] count_nxt,
    output logic             tc
);

    localparam logic [WIDTH-1:0] ONE_C = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] count_r;
    logic [WIDTH-1:0] count_nxt_s;

    // Next-count selection: load wins over increment.
    always_comb begin
        count_nxt_s = count_r;
        if (load) begin
            count_nxt_s = load_val;
        end else if (inc) begin
            count_nxt_s = count_r + ONE_C;
        end else begin
            count_nxt_s = count_r;
        end
    end

    // Count register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_r <= '0;
        end else begin
            count_r <= count_nxt_s;
        end
    end

    assign count_nxt = count_nxt_s;
    assign tc        = (count_r == last);

endmodule

// File: rtl/mmu_ctrl.sv
// Job sequencer for the NxN systolic matrix-multiply array: weight load, activation
// feed, zero-filled drain and result write-back, with all outputs registered.
module mmu_ctrl
    import mmu_ctrl_pkg::*;
#(
    parameter int ARRAY_DIM  = ARRAY_DIM_DEF,
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  abort,
    input  logic [ADDR_WIDTH-1:0] num_rows,
    input  logic [ADDR_WIDTH-1:0] w_base,
    input  logic [ADDR_WIDTH-1:0] in_base,
    input  logic [ADDR_WIDTH-1:0] out_base,
    output logic                  w_rd_en,
    output logic [ADDR_WIDTH-1:0] w_rd_addr,
    output logic                  wwrite,
    output logic                  in_rd_en,
    output logic [ADDR_WIDTH-1:0] in_rd_addr,
    output logic                  active,
    output logic                  zero_fill,
    output logic                  out_wr_en,
    output logic [ADDR_WIDTH-1:0] out_wr_addr,
    output logic                  busy,
    output logic                  done
);

    localparam int CW        = ADDR_WIDTH + 1;
    localparam int DRAIN_LEN = drain_cyc(ARRAY_DIM);
    localparam int OUT_DLY   = out_lat(ARRAY_DIM);

    localparam logic [CW-1:0] ONE_C      = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0] WLOAD_LAST = CW'(ARRAY_DIM - 1);
    // DRAIN covers the active cycle carrying the last real row plus the zero-filled flush.
    localparam logic [CW-1:0] DRAIN_LAST = CW'(DRAIN_LEN);

    mmu_state_e state_r, state_nxt_s;

    logic [CW-1:0]         rows_r;
    logic [ADDR_WIDTH-1:0] w_base_r, in_base_r, out_base_r;
    logic [ADDR_WIDTH-1:0] w_base_nxt_s;

    logic accept_s, kill_s;

    logic          ph_load_s, ph_inc_s, ph_tc_s;
    logic [CW-1:0] ph_last_s, ph_cnt_nxt_s;
    logic          row_inc_s, row_tc_s;
    logic [CW-1:0] row_last_s, row_cnt_nxt_s;

    logic [OUT_DLY-1:0] in_dly_r, in_dly_nxt_s;

    logic                  w_rd_en_r, wwrite_r, in_rd_en_r, active_r, zero_fill_r;
    logic                  out_wr_en_r, busy_r, done_r;
    logic [ADDR_WIDTH-1:0] w_rd_addr_r, in_rd_addr_r, out_wr_addr_r;

    logic                  w_rd_en_nxt_s, wwrite_nxt_s, in_rd_en_nxt_s, active_nxt_s;
    logic                  zero_fill_nxt_s, out_wr_en_nxt_s, busy_nxt_s, done_nxt_s;
    logic [ADDR_WIDTH-1:0] w_rd_addr_nxt_s, in_rd_addr_nxt_s, out_wr_addr_nxt_s;

    assign accept_s     = (state_r == IDLE) & start & ~abort;
    assign kill_s       = abort & (state_r != IDLE);
    assign w_base_nxt_s = accept_s ? w_base : w_base_r;
    assign row_last_s   = rows_r - ONE_C;
    assign row_inc_s    = out_wr_en_r & ~row_tc_s;

    mmu_ctrl_cnt #(.WIDTH(CW)) u_phase_cnt (
        .clk       (clk),
        .reset     (reset),
        .load      (ph_load_s),
        .load_val  ({CW{1'b0}}),
        .inc       (ph_inc_s),
        .last      (ph_last_s),
        .count_nxt (ph_cnt_nxt_s),
        .tc        (ph_tc_s)
    );

    mmu_ctrl_cnt #(.WIDTH(CW)) u_row_cnt (
        .clk       (clk),
        .reset     (reset),
        .load      (accept_s),
        .load_val  ({CW{1'b0}}),
        .inc       (row_inc_s),
        .last      (row_last_s),
        .count_nxt (row_cnt_nxt_s),
        .tc        (row_tc_s)
    );

    // Terminal phase index for the current state.
    always_comb begin
        ph_last_s = '0;
        case (state_r)
            WLOAD:   ph_last_s = WLOAD_LAST;
            FEED:    ph_last_s = rows_r - ONE_C;
            DRAIN:   ph_last_s = DRAIN_LAST;
            default: ph_last_s = '0;
        endcase
    end

    // Next-state and phase-counter control; abort overrides every transition.
    always_comb begin
        state_nxt_s = state_r;
        ph_load_s   = 1'b0;
        ph_inc_s    = 1'b0;
        if (kill_s) begin
            state_nxt_s = IDLE;
            ph_load_s   = 1'b1;
        end else begin
            case (state_r)
                IDLE: begin
                    if (accept_s) begin
                        ph_load_s = 1'b1;
                        if (num_rows == '0) begin
                            state_nxt_s = DONE;
                        end else begin
                            state_nxt_s = WLOAD;
                        end
                    end else begin
                        state_nxt_s = IDLE;
                    end
                end
                WLOAD: begin
                    if (ph_tc_s) begin
                        state_nxt_s = FEED;
                        ph_load_s   = 1'b1;
                    end else begin
                        ph_inc_s = 1'b1;
                    end
                end
                FEED: begin
                    if (ph_tc_s) begin
                        state_nxt_s = DRAIN;
                        ph_load_s   = 1'b1;
                    end else begin
                        ph_inc_s = 1'b1;
                    end
                end
                DRAIN: begin
                    if (ph_tc_s) begin
                        state_nxt_s = DONE;
                        ph_load_s   = 1'b1;
                    end else begin
                        ph_inc_s = 1'b1;
                    end
                end
                DONE:    state_nxt_s = IDLE;
                default: state_nxt_s = IDLE;
            endcase
        end
    end

    // Next values of the registered outputs, derived from the upcoming state and counts.
    always_comb begin
        w_rd_en_nxt_s     = (state_nxt_s == WLOAD);
        w_rd_addr_nxt_s   = w_rd_en_nxt_s ?
                            ADDR_WIDTH'({1'b0, w_base_nxt_s} + ph_cnt_nxt_s) : '0;
        wwrite_nxt_s      = w_rd_en_r & ~kill_s;
        in_rd_en_nxt_s    = (state_nxt_s == FEED);
        in_rd_addr_nxt_s  = in_rd_en_nxt_s ?
                            ADDR_WIDTH'({1'b0, in_base_r} + ph_cnt_nxt_s) : '0;
        active_nxt_s      = (in_rd_en_r & ~kill_s) | (state_nxt_s == DRAIN);
        zero_fill_nxt_s   = (state_nxt_s == DRAIN) & (ph_cnt_nxt_s != '0);
        out_wr_en_nxt_s   = in_dly_r[OUT_DLY-1] & ~kill_s;
        out_wr_addr_nxt_s = out_wr_en_nxt_s ?
                            ADDR_WIDTH'({1'b0, out_base_r} + row_cnt_nxt_s) : '0;
        busy_nxt_s        = (state_nxt_s == WLOAD) | (state_nxt_s == FEED) |
                            (state_nxt_s == DRAIN);
        done_nxt_s        = (state_nxt_s == DONE);
        // A result row emerges OUT_DLY cycles after the row it was fed with went active.
        in_dly_nxt_s      = kill_s ? '0 : {in_dly_r[OUT_DLY-2:0], in_rd_en_r};
    end

    // State and job-parameter registers; parameters are captured only on acceptance.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r    <= IDLE;
            rows_r     <= '0;
            w_base_r   <= '0;
            in_base_r  <= '0;
            out_base_r <= '0;
        end else begin
            state_r  <= state_nxt_s;
            w_base_r <= w_base_nxt_s;
            if (accept_s) begin
                rows_r     <= {1'b0, num_rows};
                in_base_r  <= in_base;
                out_base_r <= out_base;
            end else begin
                rows_r     <= rows_r;
                in_base_r  <= in_base_r;
                out_base_r <= out_base_r;
            end
        end
    end

    // Output registers and the result-latency pipeline.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            w_rd_en_r     <= 1'b0;
            w_rd_addr_r   <= '0;
            wwrite_r      <= 1'b0;
            in_rd_en_r    <= 1'b0;
            in_rd_addr_r  <= '0;
            active_r      <= 1'b0;
            zero_fill_r   <= 1'b0;
            out_wr_en_r   <= 1'b0;
            out_wr_addr_r <= '0;
            busy_r        <= 1'b0;
            done_r        <= 1'b0;
            in_dly_r      <= '0;
        end else begin
            w_rd_en_r     <= w_rd_en_nxt_s;
            w_rd_addr_r   <= w_rd_addr_nxt_s;
            wwrite_r      <= wwrite_nxt_s;
            in_rd_en_r    <= in_rd_en_nxt_s;
            in_rd_addr_r  <= in_rd_addr_nxt_s;
            active_r      <= active_nxt_s;
            zero_fill_r   <= zero_fill_nxt_s;
            out_wr_en_r   <= out_wr_en_nxt_s;
            out_wr_addr_r <= out_wr_addr_nxt_s;
            busy_r        <= busy_nxt_s;
            done_r        <= done_nxt_s;
            in_dly_r      <= in_dly_nxt_s;
        end
    end

    assign w_rd_en     = w_rd_en_r;
    assign w_rd_addr   = w_rd_addr_r;
    assign wwrite      = wwrite_r;
    assign in_rd_en    = in_rd_en_r;
    assign in_rd_addr  = in_rd_addr_r;
    assign active      = active_r;
    assign zero_fill   = zero_fill_r;
    assign out_wr_en   = out_wr_en_r;
    assign out_wr_addr = out_wr_addr_r;
    assign busy        = busy_r;
    assign done        = done_r;

endmodule

// File: tb/tb_mmu_ctrl.sv
// Scoreboard bench for mmu_ctrl: each accepted job pushes its per-cycle expected output
// vectors, and every clock the observed outputs are popped against them.
module tb_mmu_ctrl;

    localparam int N  = 4;
    localparam int AW = 8;

    logic          clk      = 1'b0;
    logic          reset    = 1'b1;
    logic          start    = 1'b0;
    logic          abort    = 1'b0;
    logic [AW-1:0] num_rows = '0;
    logic [AW-1:0] w_base   = '0;
    logic [AW-1:0] in_base  = '0;
    logic [AW-1:0] out_base = '0;

    logic          w_rd_en, wwrite, in_rd_en, active, zero_fill, out_wr_en, busy, done;
    logic [AW-1:0] w_rd_addr, in_rd_addr, out_wr_addr;

    always #5 clk = ~clk;

    mmu_ctrl #(.ARRAY_DIM(N), .ADDR_WIDTH(AW)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .abort       (abort),
        .num_rows    (num_rows),
        .w_base      (w_base),
        .in_base     (in_base),
        .out_base    (out_base),
        .w_rd_en     (w_rd_en),
        .w_rd_addr   (w_rd_addr),
        .wwrite      (wwrite),
        .in_rd_en    (in_rd_en),
        .in_rd_addr  (in_rd_addr),
        .active      (active),
        .zero_fill   (zero_fill),
        .out_wr_en   (out_wr_en),
        .out_wr_addr (out_wr_addr),
        .busy        (busy),
        .done        (done)
    );

    // {w_rd_en, w_rd_addr, wwrite, in_rd_en, in_rd_addr, active, zero_fill,
    //  out_wr_en, out_wr_addr, busy, done}
    wire [31:0] obs_s = {w_rd_en, w_rd_addr, wwrite, in_rd_en, in_rd_addr, active,
                         zero_fill, out_wr_en, out_wr_addr, busy, done};

    logic [31:0] exp_q[$];
    logic [31:0] exp_v;
    int          n_tests = 0;
    int          n_fail  = 0;

    // Expected outputs 'rel' cycles after the cycle in which the job's start was accepted.
    function automatic logic [31:0] exp_vec(input int rel, input int nr,
                                            input logic [7:0] wb, input logic [7:0] ib,
                                            input logic [7:0] ob);
        logic       we, ww, ie, ac, zf, oe, bz, dn;
        logic [7:0] wa, ia, oa;
        we = 1'b0; ww = 1'b0; ie = 1'b0; ac = 1'b0; zf = 1'b0; oe = 1'b0; bz = 1'b0;
        wa = 8'h00; ia = 8'h00; oa = 8'h00;
        if (nr == 0) begin
            dn = (rel == 1);
        end else begin
            we = (rel >= 1) && (rel <= N);
            ww = (rel >= 2) && (rel <= N + 1);
            ie = (rel >= N + 1) && (rel <= N + nr);
            ac = (rel >= N + 2) && (rel <= N + nr + 2 * N);
            zf = (rel >= N + nr + 2) && (rel <= N + nr + 2 * N);
            oe = (rel >= 3 * N + 1) && (rel <= 3 * N + nr);
            bz = (rel >= 1) && (rel <= 3 * N + nr);
            dn = (rel == 3 * N + nr + 1);
            if (we) wa = wb + 8'(rel - 1);
            if (ie) ia = ib + 8'(rel - N - 1);
            if (oe) oa = ob + 8'(rel - 3 * N - 1);
        end
        return {we, wa, ww, ie, ia, ac, zf, oe, oa, bz, dn};
    endfunction

    task automatic push_job(input int nr, input logic [7:0] wb, input logic [7:0] ib,
                            input logic [7:0] ob);
        int last;
        last = (nr == 0) ? 1 : 3 * N + nr + 1;
        for (int rel = 1; rel <= last; rel++) exp_q.push_back(exp_vec(rel, nr, wb, ib, ob));
    endtask

    task automatic drive_start(input int nr, input logic [7:0] wb, input logic [7:0] ib,
                               input logic [7:0] ob);
        start    = 1'b1;
        num_rows = 8'(nr);
        w_base   = wb;
        in_base  = ib;
        out_base = ob;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #12;
        n_tests++;
        if (obs_s !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_state got %h expected %h", obs_s, 32'h0);
        end
        @(negedge clk);
        reset = 1'b0;
        tick();
    endtask

    task automatic test_basic(input string name, input int nr, input logic [7:0] wb,
                              input logic [7:0] ib, input logic [7:0] ob);
        int writes;
        int dones;
        writes = 0;
        dones  = 0;
        drive_start(nr, wb, ib, ob);
        push_job(nr, wb, ib, ob);
        for (int c = 1; c <= 3 * N + nr + 4; c++) begin
            tick();
            exp_v = (exp_q.size() > 0) ? exp_q.pop_front() : 32'h0;
            n_tests++;
            if (obs_s !== exp_v) begin
                n_fail++;
                $display("FAIL %s c%0d got %h expected %h", name, c, obs_s, exp_v);
            end
            if (out_wr_en === 1'b1) writes++;
            if (done === 1'b1) dones++;
            start = 1'b0;
        end
        n_tests++;
        if (writes != nr) begin
            n_fail++;
            $display("FAIL %s_write_count got %0d expected %0d", name, writes, nr);
        end
        n_tests++;
        if (dones != 1) begin
            n_fail++;
            $display("FAIL %s_done_count got %0d expected 1", name, dones);
        end
    endtask

    task automatic test_back_to_back();
        drive_start(3, 8'h10, 8'h20, 8'h30);
        push_job(3, 8'h10, 8'h20, 8'h30);
        for (int c = 1; c <= 34; c++) begin
            tick();
            exp_v = (exp_q.size() > 0) ? exp_q.pop_front() : 32'h0;
            n_tests++;
            if (obs_s !== exp_v) begin
                n_fail++;
                $display("FAIL back_to_back c%0d got %h expected %h", c, obs_s, exp_v);
            end
            if (c == 8 || c == 16 || c == 17) begin
                drive_start(1, 8'h40, 8'h50, 8'h60);
                if (c == 17) push_job(1, 8'h40, 8'h50, 8'h60);
            end else begin
                start = 1'b0;
            end
        end
    endtask

    task automatic test_abort();
        int dones;
        dones = 0;
        drive_start(3, 8'h10, 8'h20, 8'h30);
        push_job(3, 8'h10, 8'h20, 8'h30);
        for (int c = 1; c <= 20; c++) begin
            tick();
            exp_v = (exp_q.size() > 0) ? exp_q.pop_front() : 32'h0;
            n_tests++;
            if (obs_s !== exp_v) begin
                n_fail++;
                $display("FAIL abort c%0d got %h expected %h", c, obs_s, exp_v);
            end
            if (done === 1'b1) dones++;
            start = 1'b0;
            if (c == 10) begin
                abort = 1'b1;
                exp_q.delete();
            end else begin
                abort = 1'b0;
            end
        end
        n_tests++;
        if (dones != 0) begin
            n_fail++;
            $display("FAIL abort_no_done got %0d expected 0", dones);
        end
        // start and abort together in IDLE must not launch a job
        drive_start(3, 8'h10, 8'h20, 8'h30);
        abort = 1'b1;
        for (int c = 1; c <= 6; c++) begin
            tick();
            start = 1'b0;
            abort = 1'b0;
            n_tests++;
            if (obs_s !== 32'h0) begin
                n_fail++;
                $display("FAIL start_abort_idle c%0d got %h expected %h", c, obs_s, 32'h0);
            end
        end
    endtask

    task automatic test_reset_mid();
        drive_start(3, 8'h10, 8'h20, 8'h30);
        push_job(3, 8'h10, 8'h20, 8'h30);
        for (int c = 1; c <= 7; c++) begin
            tick();
            exp_v = (exp_q.size() > 0) ? exp_q.pop_front() : 32'h0;
            n_tests++;
            if (obs_s !== exp_v) begin
                n_fail++;
                $display("FAIL reset_mid c%0d got %h expected %h", c, obs_s, exp_v);
            end
            start = 1'b0;
        end
        #2;
        reset = 1'b1;
        #1;
        n_tests++;
        if (obs_s !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_async got %h expected %h", obs_s, 32'h0);
        end
        exp_q.delete();
        tick();
        #2;
        reset = 1'b0;
        tick();
        test_basic("after_reset", 3, 8'h10, 8'h20, 8'h30);
    endtask

    initial begin
        test_reset();
        test_basic("basic", 3, 8'h10, 8'h20, 8'h30);
        test_basic("zero_rows", 0, 8'h10, 8'h20, 8'h30);
        test_back_to_back();
        test_abort();
        test_reset_mid();
        test_basic("wrap", 2, 8'hFE, 8'h7F, 8'hFF);
        test_basic("long", 9, 8'h05, 8'hF9, 8'h80);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
